// File: rtl/md_cart_responder.sv
// Cartridge-side responder: ROM reads via req/ack, battery byte SRAM, /TIME control regs.
// Define MD_CART_SSF2_MAPPER_EN to add the 8-slot bank mapper (bank regs at /TIME idx1..7).
module md_cart_responder #(
  parameter int unsigned SRAM_AW = 13,
  parameter int unsigned ROM_AW  = 24
) (
  input  logic              MCLK,
  input  logic              ext_reset_n,
  input  logic [22:0]       cart_address,
  input  logic              cart_cs,
  input  logic              cart_oe,
  input  logic              cart_lwr,
  input  logic              cart_uwr,
  input  logic              cart_time,
  input  logic [15:0]       cart_data_wr,
  output logic [15:0]       cart_data,
  output logic              cart_data_en,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [15:0]       rom_data
);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StSram1, StHold} state_e;

  state_e              state_q;
  logic [15:0]         cart_data_q;
  logic                en_q;
  logic                req_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [1:0]          ctrl_q;
  logic                rd_lvl_q, wr_lvl_q, tw_lvl_q;
  logic [7:0]          sram_q [2**SRAM_AW];

  logic                rd_lvl, wr_lvl, tw_lvl;
  logic                rd_rise, wr_rise, tw_rise;
  logic [2:0]          slot;
  logic                sram_hit;
  logic                sram_we;
  logic                reg_sel;
  logic [2:0]          reg_idx;
  logic [SRAM_AW-1:0]  sram_idx;
  logic [23:0]         phys;

  assign rd_lvl   = cart_cs & cart_oe;
  assign wr_lvl   = cart_cs & cart_lwr;
  assign tw_lvl   = cart_time & cart_lwr;
  assign wr_rise  = wr_lvl & ~wr_lvl_q;
  // A write edge coinciding with a read edge wins; that read is never started.
  assign rd_rise  = rd_lvl & ~rd_lvl_q & ~wr_rise;
  assign tw_rise  = tw_lvl & ~tw_lvl_q;
  assign slot     = cart_address[20:18];
  assign sram_hit = ctrl_q[0] & (slot == 3'd4);
  assign sram_we  = wr_rise & sram_hit & ~ctrl_q[1];
  assign sram_idx = cart_address[SRAM_AW-1:0];
  assign reg_sel  = tw_rise & (cart_address[6:3] == 4'hF);
  assign reg_idx  = cart_address[2:0];

`ifdef MD_CART_SSF2_MAPPER_EN
  logic [5:0] bank_q [8];

  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= 6'(i);
    end else if (reg_sel && reg_idx != 3'd0) begin
      bank_q[reg_idx] <= cart_data_wr[5:0];
    end
  end

  assign phys = {bank_q[slot], cart_address[17:0]};
`else
  assign phys = {3'b000, cart_address[20:0]};
`endif

  logic unused_ok;
  assign unused_ok = ^{cart_address[22:21], cart_data_wr[15:8], cart_uwr};

  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      rd_lvl_q <= 1'b0;
      wr_lvl_q <= 1'b0;
      tw_lvl_q <= 1'b0;
      ctrl_q   <= 2'b00;
    end else begin
      rd_lvl_q <= rd_lvl;
      wr_lvl_q <= wr_lvl;
      tw_lvl_q <= tw_lvl;
      if (reg_sel && reg_idx == 3'd0) ctrl_q <= cart_data_wr[1:0];
    end
  end

  // SRAM contents survive reset (battery-backed).
  always_ff @(posedge MCLK) begin
    if (sram_we) sram_q[sram_idx] <= cart_data_wr[7:0];
  end

  always_ff @(posedge MCLK or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q     <= StIdle;
      cart_data_q <= 16'h0000;
      en_q        <= 1'b0;
      req_q       <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_rise) begin
            if (sram_hit) begin
              state_q <= StSram1;
            end else begin
              state_q    <= StFetch;
              req_q      <= 1'b1;
              rom_addr_q <= ROM_AW'(phys);
            end
          end
        end
        StFetch: begin
          if (rom_ack) begin
            req_q <= 1'b0;
            if (rd_lvl) begin
              cart_data_q <= rom_data;
              en_q        <= 1'b1;
              state_q     <= StHold;
            end else begin
              state_q <= StIdle;
            end
          end else if (!rd_lvl) begin
            state_q <= StDrain;
          end
        end
        // Aborted fetch: the memory still owes an ack; swallow it.
        StDrain: begin
          if (rom_ack) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        StSram1: begin
          if (rd_lvl) begin
            cart_data_q <= {8'hFF, sram_q[sram_idx]};
            en_q        <= 1'b1;
            state_q     <= StHold;
          end else begin
            state_q <= StIdle;
          end
        end
        StHold: begin
          if (!rd_lvl) begin
            en_q    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cart_data    = cart_data_q;
  assign cart_data_en = en_q;
  assign rom_req      = req_q;
  assign rom_addr     = rom_addr_q;

endmodule

// File: tb/tb_md_cart_responder.sv
// Directed self-checking bench for md_cart_responder; honours MD_CART_SSF2_MAPPER_EN.
module tb_md_cart_responder;

  logic        MCLK = 1'b0;
  logic        ext_reset_n;
  logic [22:0] cart_address;
  logic        cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        cart_data_en;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MD_CART_SSF2_MAPPER_EN
  localparam logic [23:0] MappedAddr = 24'h280002;
`else
  localparam logic [23:0] MappedAddr = 24'h040002;
`endif

  md_cart_responder #(.SRAM_AW(13), .ROM_AW(24)) dut (
    .MCLK         (MCLK),
    .ext_reset_n  (ext_reset_n),
    .cart_address (cart_address),
    .cart_cs      (cart_cs),
    .cart_oe      (cart_oe),
    .cart_lwr     (cart_lwr),
    .cart_uwr     (cart_uwr),
    .cart_time    (cart_time),
    .cart_data_wr (cart_data_wr),
    .cart_data    (cart_data),
    .cart_data_en (cart_data_en),
    .rom_req      (rom_req),
    .rom_addr     (rom_addr),
    .rom_ack      (rom_ack),
    .rom_data     (rom_data)
  );

  always #5 MCLK = ~MCLK;

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic time_write(input logic [2:0] idx, input logic [15:0] data);
    cart_address = 23'h284C78 | 23'(idx);
    cart_data_wr = data;
    cart_time = 1'b1;
    cart_lwr  = 1'b1;
    cyc(1);
    cart_time = 1'b0;
    cart_lwr  = 1'b0;
    cyc(1);
  endtask

  task automatic sram_write(input logic [22:0] addr, input logic [15:0] data, input bit lane_lo);
    cart_address = addr;
    cart_data_wr = data;
    cart_cs = 1'b1;
    if (lane_lo) cart_lwr = 1'b1;
    else cart_uwr = 1'b1;
    cyc(1);
    cart_cs  = 1'b0;
    cart_lwr = 1'b0;
    cart_uwr = 1'b0;
    cyc(1);
  endtask

  task automatic sram_read(input string tag, input logic [22:0] addr, input logic [15:0] exp);
    cart_address = addr;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    cyc(1);
    check({tag, "_en_early"}, 32'(cart_data_en), 32'd0);
    cyc(1);
    check({tag, "_en"}, 32'(cart_data_en), 32'd1);
    check({tag, "_data"}, 32'(cart_data), 32'(exp));
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    cyc(1);
    check({tag, "_en_drop"}, 32'(cart_data_en), 32'd0);
  endtask

  task automatic rom_read(input string tag, input logic [22:0] addr, input int delay,
                          input logic [15:0] data, input logic [23:0] exp_addr);
    cart_address = addr;
    cart_cs = 1'b1;
    cart_oe = 1'b1;
    cyc(1);
    check({tag, "_req"}, 32'(rom_req), 32'd1);
    check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    if (delay > 0) cyc(delay);
    rom_ack  = 1'b1;
    rom_data = data;
    check({tag, "_en_at_ack"}, 32'(cart_data_en), 32'd0);
    cyc(1);
    rom_ack = 1'b0;
    check({tag, "_en"}, 32'(cart_data_en), 32'd1);
    check({tag, "_data"}, 32'(cart_data), 32'(data));
    check({tag, "_req_off"}, 32'(rom_req), 32'd0);
    cart_cs = 1'b0;
    cart_oe = 1'b0;
    cyc(1);
    check({tag, "_en_drop"}, 32'(cart_data_en), 32'd0);
  endtask

  initial begin
    ext_reset_n  = 1'b0;
    cart_address = '0;
    cart_cs = 1'b0; cart_oe = 1'b0; cart_lwr = 1'b0; cart_uwr = 1'b0; cart_time = 1'b0;
    cart_data_wr = '0;
    rom_ack  = 1'b0;
    rom_data = '0;
    #12;
    check("rst_data", 32'(cart_data), 32'd0);
    check("rst_en", 32'(cart_data_en), 32'd0);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    cyc(1);
    ext_reset_n = 1'b1;
    cyc(1);

    // Basic ROM fetch, ack three clocks after the strobe.
    rom_read("rom1", 23'h000100, 2, 16'h4E71, 24'h000100);

    // SRAM unmapped after reset: slot 4 reads go to ROM.
    rom_read("slot4_rom", 23'h100000, 0, 16'hBEEF, 24'h100000);

    // Map SRAM, write, read back.
    time_write(3'd0, 16'h0001);
    sram_write(23'h100000, 16'h005A, 1'b1);
    sram_read("sram1", 23'h100000, 16'hFF5A);

    // Upper-lane-only write is ignored.
    sram_write(23'h100000, 16'h7777, 1'b0);
    sram_read("uwr_only", 23'h100000, 16'hFF5A);

    // Write-protect blocks the write.
    time_write(3'd0, 16'h0003);
    sram_write(23'h100000, 16'h00A5, 1'b1);
    sram_read("wprot", 23'h100000, 16'hFF5A);
    time_write(3'd0, 16'h0001);
    sram_write(23'h100001, 16'h003C, 1'b1);
    sram_read("sram2", 23'h100001, 16'hFF3C);

    // Non-register /TIME address must not touch ctrl.
    cart_address = 23'h284C70;
    cart_data_wr = 16'h0000;
    cart_time = 1'b1; cart_lwr = 1'b1;
    cyc(1);
    cart_time = 1'b0; cart_lwr = 1'b0;
    cyc(1);
    sram_read("time_miss", 23'h100000, 16'hFF5A);

    // Bank mapper for slot 1.
    time_write(3'd1, 16'h000A);
    rom_read("map", 23'h040002, 0, 16'h1111, MappedAddr);

    // Abort during fetch; a new strobe while draining is ignored.
    cart_address = 23'h000200;
    cart_cs = 1'b1; cart_oe = 1'b1;
    cyc(1);
    check("abort_addr", 32'(rom_addr), 32'h000200);
    cart_cs = 1'b0; cart_oe = 1'b0;
    cyc(2);
    check("abort_req_held", 32'(rom_req), 32'd1);
    cart_address = 23'h000300;
    cart_cs = 1'b1; cart_oe = 1'b1;
    cyc(1);
    check("abort_addr_kept", 32'(rom_addr), 32'h000200);
    rom_ack = 1'b1; rom_data = 16'hDEAD;
    cyc(1);
    rom_ack = 1'b0;
    check("abort_en", 32'(cart_data_en), 32'd0);
    check("abort_req_off", 32'(rom_req), 32'd0);
    cyc(1);
    check("abort_en_late", 32'(cart_data_en), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0;
    cyc(1);
    rom_read("after_abort", 23'h000300, 1, 16'h1234, 24'h000300);

    // Simultaneous oe and lwr: write wins, no read.
    cart_address = 23'h100002;
    cart_data_wr = 16'h0066;
    cart_cs = 1'b1; cart_oe = 1'b1; cart_lwr = 1'b1;
    cyc(2);
    check("simul_en", 32'(cart_data_en), 32'd0);
    check("simul_req", 32'(rom_req), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0; cart_lwr = 1'b0;
    cyc(1);
    sram_read("simul_rd", 23'h100002, 16'hFF66);

    // Asynchronous reset in the middle of a fetch.
    cart_address = 23'h040002;
    cart_cs = 1'b1; cart_oe = 1'b1;
    cyc(1);
    check("rstf_req_pre", 32'(rom_req), 32'd1);
    #2;
    ext_reset_n = 1'b0;
    #1;
    check("rstf_req_async", 32'(rom_req), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0;
    rom_ack = 1'b1; rom_data = 16'hBAD0;
    cyc(1);
    ext_reset_n = 1'b1;
    cyc(1);
    rom_ack = 1'b0;
    check("rstf_late_en", 32'(cart_data_en), 32'd0);
    check("rstf_late_req", 32'(rom_req), 32'd0);
    rom_read("rstf_bank", 23'h040002, 0, 16'h5555, 24'h040002);
    rom_read("rstf_ctrl", 23'h100000, 0, 16'h6666, 24'h100000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
